// File: rtl/wr_ptr_ctrl_af.sv
// wr_ptr_ctrl_af: async FIFO write-side pointer controller with fill level and programmable almost-full
//   Optional build macro: WPTR_OVF_EN enables the sticky overflow flag (otherwise w_overflow is tied 0).
//   Ports:
//     w_clk, w_rst_n     write clock, asynchronous active-low reset
//     w_en               write request (accepted only when not full)
//     s_rd_ptr           Gray read pointer already synchronised into w_clk
//     af_wr, af_thresh_in  load the almost-full threshold (fill-level units)
//     w_ovf_clr          clear the sticky overflow flag
//     w_addr             RAM write address
//     w_ptr              registered Gray write pointer for the synchroniser
//     w_full, w_almost_full, w_level  registered status as seen from the write domain
//     w_overflow         sticky write-while-full flag
module wr_ptr_ctrl_af #(
  parameter int ADDR_W = 4,
  parameter int AF_RST = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_en,
  input  logic [ADDR_W:0]   s_rd_ptr,
  input  logic              af_wr,
  input  logic [ADDR_W:0]   af_thresh_in,
  input  logic              w_ovf_clr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_ptr,
  output logic              w_full,
  output logic              w_almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              w_overflow
);
  localparam logic [ADDR_W:0] THR_RST = AF_RST[ADDR_W:0];
  logic [ADDR_W:0] w_bin, w_bin_nxt, w_gray_nxt, rd_bin, level_nxt, thr;
  logic            w_acc;
  assign w_acc      = w_en & ~w_full;
  assign w_bin_nxt  = w_bin + {{ADDR_W{1'b0}}, w_acc};
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  assign w_addr     = w_bin[ADDR_W-1:0];
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar g = 0; g <= ADDR_W; g++) begin : g_dec
    assign rd_bin[g] = ^s_rd_ptr[ADDR_W:g];
  end
  // Modular difference of the extra-MSB pointers gives 0..2**ADDR_W.
  assign level_nxt = w_bin_nxt - rd_bin;
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_bin         <= '0;
      w_ptr         <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      thr           <= THR_RST;
    end else begin
      w_bin         <= w_bin_nxt;
      w_ptr         <= w_gray_nxt;
      // Full when write is exactly one lap ahead: top two Gray bits inverted, rest equal.
      w_full        <= w_gray_nxt == {~s_rd_ptr[ADDR_W:ADDR_W-1], s_rd_ptr[ADDR_W-2:0]};
      w_almost_full <= level_nxt >= thr;
      w_level       <= level_nxt;
      if (af_wr) thr <= af_thresh_in;
    end
  end
`ifdef WPTR_OVF_EN
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) w_overflow <= 1'b0;
    else if (w_en & w_full) w_overflow <= 1'b1;
    else if (w_ovf_clr) w_overflow <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = w_ovf_clr;
  assign w_overflow     = 1'b0;
`endif
endmodule

// File: doc/wr_ptr_ctrl_af.md
Name: wr_ptr_ctrl_af

Overview:
Write-domain pointer controller for the async FIFO, generalised from the basic write pointer.
- Keeps the binary write address and registered Gray write pointer.
- Gates writes against full.
- Converts the synchronised Gray read pointer back to binary, so it can also report fill level and a programmable almost-full flag.
- Sits between the write-side client, the dual-port RAM write port and the read-to-write pointer synchroniser.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
AF_RST, 12, reset value of the almost-full threshold register (must be <= 2**ADDR_W).

Ports:
- w_clk  input  1  write-domain clock.
- w_rst_n  input  1  asynchronous, active-low reset.
- w_en  input  1  write request; accepted only when w_full=0.
- s_rd_ptr  input  ADDR_W+1  Gray read pointer, already 2-flop synchronised into w_clk.
- af_wr  input  1  load af_thresh_in into the threshold register this cycle.
- af_thresh_in  input  ADDR_W+1  new almost-full threshold (fill-level units).
- w_ovf_clr  input  1  clear sticky overflow flag.
- w_addr  output  ADDR_W  RAM write address (low bits of binary pointer).
- w_ptr  output  ADDR_W+1  registered Gray write pointer, to synchroniser.
- w_full  output  1  FIFO full, registered.
- w_almost_full  output  1  fill level >= threshold, registered.
- w_level  output  ADDR_W+1  fill level as seen from write domain, registered, range 0..2**ADDR_W.
- w_overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (async assert, sync release on w_clk). All flops clear: w_bin=0, w_ptr=0, w_full=0, w_level=0, w_overflow=0. w_almost_full resets to 0 (AF_RST>0 assumed). Threshold register resets to AF_RST.
- Accept: w_acc = w_en & ~w_full. Next binary pointer w_bin_nxt = w_bin + w_acc, mod 2**(ADDR_W+1), so wrap is natural.
- Gray encode: w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1); registered into w_ptr. w_ptr changes at most one bit per cycle.
- Read pointer decode: rd_bin is the combinational Gray-to-binary of s_rd_ptr: rd_bin[ADDR_W] = g[ADDR_W]; rd_bin[i] = rd_bin[i+1] ^ g[i].
- Level: level_nxt = (w_bin_nxt - rd_bin) mod 2**(ADDR_W+1). w_level <= level_nxt each cycle.
- Full: w_full <= (w_gray_nxt == {~s_rd_ptr[ADDR_W:ADDR_W-1], s_rd_ptr[ADDR_W-2:0]}). This is equivalent to level_nxt == 2**ADDR_W; implementation must use the Gray compare.
- Almost-full: w_almost_full <= (level_nxt >= thr). A threshold of 0 keeps the flag asserted permanently.
- Threshold load: af_wr loads thr <= af_thresh_in; the new value takes effect on the following cycle's comparison.
- Latency:
  - Accepted write: w_addr, w_ptr, w_level and w_full update on the same edge.
  - Read-side freeing: visible only via s_rd_ptr; flags deassert one w_clk after s_rd_ptr changes.
- Write while full: ignored; pointer and RAM address unchanged.
- Simultaneous write and s_rd_ptr advance: level unchanged; full cannot assert.
- Flags are pessimistic because of synchroniser lag: w_level may overstate the true fill, never understate it.
- Mid-operation reset returns all state to reset values immediately. The read side must be reset together with this block.

Optional Feature:
WPTR_OVF_EN
- Defined: w_overflow <= 1 when w_en & w_full. It stays set until w_ovf_clr. If set and clear coincide, set wins.
- Not defined: no overflow flop; w_overflow is tied 0 and w_ovf_clr is ignored.

Test Plan:
1. Reset, ADDR_W=4, s_rd_ptr=0: write 1 word/cycle for 16 cycles.
   - Expect w_addr 0..15.
   - w_full=1 after the 16th edge, w_level=16, w_ptr=5'b11000 (Gray of 16).
   - w_almost_full rises after the 12th accepted write.
2. Full hold: w_en=1 for 5 more cycles.
   - Expect w_bin and w_ptr unchanged, w_level=16.
   - With WPTR_OVF_EN, w_overflow=1 until w_ovf_clr pulses, then 0.
3. Drain: step s_rd_ptr through Gray 1..4.
   - Expect w_full=0 one cycle after the first change; w_level 15,14,13,12; w_almost_full still 1 at level 12.
   - At Gray 5 (level 11), w_almost_full=0.
4. Wrap: run 40 write/read pairs with s_rd_ptr tracking.
   - Expect w_ptr wrapping 31->0 with a single-bit change.
   - w_level stays constant and w_full never asserts.
5. Threshold: af_wr with af_thresh_in=3 at level 2.
   - Expect w_almost_full=0, then 1 after the next accepted write (level 3).
   - af_thresh_in=0 gives constant 1.
6. Reset at level 9 mid-burst: assert w_rst_n=0 asynchronously.
   - Expect all outputs 0 immediately and the threshold back to AF_RST.
